// File: rtl/lens_filter_ctrl_pkg.sv
// Shared types and constants for the lens filter control block.
package lens_filter_pkg;

  localparam int unsigned NUM_BTNS = 5;
  localparam int unsigned FILTER_W = 3;
  localparam int unsigned LEVEL_W  = 4;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

  typedef logic [FILTER_W-1:0] filter_sel_t;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_PRESSED = 2'd1,
    C_LONG    = 2'd2
  } center_state_t;

endpackage

// File: rtl/lens_filter_ctrl_if.sv
// Button-in / filter-control-out bundle between debounce stage, this block and the datapath.
interface lens_filter_ctrl_if;

  logic [4:0]                 btn;
  lens_filter_pkg::filter_sel_t filter_sel;
  logic [3:0]                 level;
  logic                       freeze;
  logic                       cfg_changed;

  modport master (output btn, input filter_sel, level, freeze, cfg_changed);
  modport slave  (input btn, output filter_sel, level, freeze, cfg_changed);

endinterface

// File: rtl/lens_filter_ctrl_btn_hold_timer.sv
// Hold-to-repeat timer: first step after HOLD_DELAY held cycles, then every REPEAT_PERIOD.
module btn_hold_timer #(
  parameter int unsigned HOLD_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic held,
  input  logic restart,
  output logic step_c
);

  localparam int unsigned CNT_W = $clog2(HOLD_DELAY + 1);

  logic [CNT_W-1:0] cnt;

  assign step_c = held && (cnt == CNT_W'(HOLD_DELAY));

  // Reloading to HOLD_DELAY-REPEAT_PERIOD+1 makes the next match REPEAT_PERIOD cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!held) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CNT_W'(1);
    end else if (step_c) begin
      cnt <= CNT_W'(HOLD_DELAY - REPEAT_PERIOD + 1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lens_filter_ctrl.sv
// Button levels -> filter select / strength / freeze control with change pulse.
// Auto-repeat of up/down is built only when LENS_FILTER_CTRL_AUTOREPEAT_EN is defined.
module lens_filter_ctrl
  import lens_filter_pkg::*;
#(
  parameter int unsigned NUM_FILTERS   = 6,
  parameter int unsigned LEVEL_MAX     = 15,
  parameter int unsigned LEVEL_DEFAULT = 8,
  parameter int unsigned HOLD_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned LONG_PRESS    = 100_000_000
) (
  input logic               clk,
  input logic               reset,
  lens_filter_ctrl_if.slave bus
);

  localparam int unsigned PRESS_W = $clog2(LONG_PRESS);

  logic [NUM_BTNS-1:0] btn_q;
  logic [NUM_BTNS-1:0] rise_c;
  center_state_t       c_state, c_nxt;
  logic [PRESS_W-1:0]  press_cnt, press_nxt;
  filter_sel_t         filter_q, filter_nxt;
  logic [LEVEL_W-1:0]  level_q, level_nxt;
  logic                freeze_q, freeze_nxt;
  logic                cfg_changed_q;
  logic                rep_step_c;
  logic                up_c, down_c;

  assign rise_c = bus.btn & ~btn_q;

`ifdef LENS_FILTER_CTRL_AUTOREPEAT_EN
  logic held_one_c;
  assign held_one_c = bus.btn[BTN_UP] ^ bus.btn[BTN_DOWN];

  btn_hold_timer #(
    .HOLD_DELAY    (HOLD_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_updown_timer (
    .clk     (clk),
    .reset   (reset),
    .held    (held_one_c),
    .restart (rise_c[BTN_UP] | rise_c[BTN_DOWN]),
    .step_c  (rep_step_c)
  );
`else
  assign rep_step_c = 1'b0;
`endif

  // Both up and down high suppresses stepping entirely.
  assign up_c   = bus.btn[BTN_UP]   & ~bus.btn[BTN_DOWN] & (rise_c[BTN_UP]   | rep_step_c);
  assign down_c = bus.btn[BTN_DOWN] & ~bus.btn[BTN_UP]   & (rise_c[BTN_DOWN] | rep_step_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) c_state <= C_IDLE;
    else       c_state <= c_nxt;
  end

  // Centre FSM plus next values of all control outputs.
  always_comb begin
    c_nxt      = c_state;
    press_nxt  = press_cnt;
    filter_nxt = filter_q;
    level_nxt  = level_q;
    freeze_nxt = freeze_q;

    if (rise_c[BTN_RIGHT] && !rise_c[BTN_LEFT]) begin
      filter_nxt = (filter_q == filter_sel_t'(NUM_FILTERS - 1)) ? '0 : filter_q + FILTER_W'(1);
    end else if (rise_c[BTN_LEFT] && !rise_c[BTN_RIGHT]) begin
      filter_nxt = (filter_q == '0) ? filter_sel_t'(NUM_FILTERS - 1) : filter_q - FILTER_W'(1);
    end

    if (up_c && level_q != LEVEL_W'(LEVEL_MAX)) begin
      level_nxt = level_q + LEVEL_W'(1);
    end else if (down_c && level_q != '0) begin
      level_nxt = level_q - LEVEL_W'(1);
    end

    unique case (c_state)
      C_IDLE: begin
        if (rise_c[BTN_CENTER]) begin
          c_nxt     = C_PRESSED;
          press_nxt = '0;
        end
      end
      C_PRESSED: begin
        if (bus.btn[BTN_CENTER]) begin
          press_nxt = press_cnt + PRESS_W'(1);
          if (press_nxt == PRESS_W'(LONG_PRESS - 1)) begin
            c_nxt      = C_LONG;
            filter_nxt = '0;
            level_nxt  = LEVEL_W'(LEVEL_DEFAULT);
            freeze_nxt = 1'b0;
          end
        end else begin
          c_nxt      = C_IDLE;
          freeze_nxt = ~freeze_q;
        end
      end
      C_LONG: begin
        if (!bus.btn[BTN_CENTER]) c_nxt = C_IDLE;
      end
      default: c_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q         <= '0;
      press_cnt     <= '0;
      filter_q      <= '0;
      level_q       <= LEVEL_W'(LEVEL_DEFAULT);
      freeze_q      <= 1'b0;
      cfg_changed_q <= 1'b0;
    end else begin
      btn_q         <= bus.btn;
      press_cnt     <= press_nxt;
      filter_q      <= filter_nxt;
      level_q       <= level_nxt;
      freeze_q      <= freeze_nxt;
      cfg_changed_q <= (filter_nxt != filter_q) || (level_nxt != level_q) ||
                       (freeze_nxt != freeze_q);
    end
  end

  assign bus.filter_sel  = filter_q;
  assign bus.level       = level_q;
  assign bus.freeze      = freeze_q;
  assign bus.cfg_changed = cfg_changed_q;

endmodule

// File: tb/tb_lens_filter_ctrl.sv
// Randomised + directed bench for lens_filter_ctrl against a cycle-level behavioural model.
module tb_lens_filter_ctrl;

  localparam int NF = 6;
  localparam int LMAX = 15;
  localparam int LDEF = 8;
  localparam int HD = 20;
  localparam int RP = 5;
  localparam int LP = 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lens_filter_ctrl_if bus ();

  lens_filter_ctrl #(
    .NUM_FILTERS   (NF),
    .LEVEL_MAX     (LMAX),
    .LEVEL_DEFAULT (LDEF),
    .HOLD_DELAY    (HD),
    .REPEAT_PERIOD (RP),
    .LONG_PRESS    (LP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts of held cycles, modulo arithmetic, saturating integers.
  int m_sel, m_lvl, m_frz, m_chg;
  logic [4:0] m_prev;
  int run;
  bit run_up;
  bit press_active;
  int press_len;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sel = 0; m_lvl = LDEF; m_frz = 0; m_chg = 0;
      m_prev = '0; run = 0; run_up = 0; press_active = 0; press_len = 0;
    end else begin
      logic [4:0] b, r;
      int n_sel, n_lvl, n_frz;
      bit one, rep, restore, step_rise;
      b = bus.btn;
      r = b & ~m_prev;
      n_sel = m_sel; n_lvl = m_lvl; n_frz = m_frz; restore = 0;

      if (r[3] && !r[2]) n_sel = (m_sel + 1) % NF;
      else if (r[2] && !r[3]) n_sel = (m_sel + NF - 1) % NF;

      one = b[0] ^ b[1];
      if (!one) run = 0;
      else if (run > 0 && run_up == b[0]) run++;
      else run = 1;
      run_up = b[0];
`ifdef LENS_FILTER_CTRL_AUTOREPEAT_EN
      rep = (run > HD) && (((run - 1 - HD) % RP) == 0);
`else
      rep = 0;
`endif
      step_rise = b[0] ? r[0] : r[1];
      if (one && (step_rise || rep)) begin
        if (b[0]) n_lvl = (m_lvl < LMAX) ? m_lvl + 1 : LMAX;
        else      n_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
      end

      if (r[4]) begin
        press_active = 1; press_len = 1;
      end else if (press_active && b[4]) begin
        press_len++;
        if (press_len == LP) begin restore = 1; press_active = 0; end
      end else if (press_active) begin
        n_frz = 1 - m_frz; press_active = 0;
      end
      if (restore) begin n_sel = 0; n_lvl = LDEF; n_frz = 0; end

      m_chg = (n_sel != m_sel || n_lvl != m_lvl || n_frz != m_frz) ? 1 : 0;
      m_sel = n_sel; m_lvl = n_lvl; m_frz = n_frz;
      m_prev = b;
    end
  end

  always @(negedge clk) begin
    chk("model_filter_sel", int'(bus.filter_sel), m_sel);
    chk("model_level", int'(bus.level), m_lvl);
    chk("model_freeze", int'(bus.freeze), m_frz);
    chk("model_cfg_changed", int'(bus.cfg_changed), m_chg);
    if (bus.cfg_changed) pulse_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx, input int hi, input int lo);
    bus.btn[idx] = 1'b1;
    cyc(hi);
    bus.btn[idx] = 1'b0;
    cyc(lo);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.btn = '0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  int exp_r[7] = '{1, 2, 3, 4, 5, 0, 1};
  int exp_up;

  initial begin
    bus.btn = '0;
    #1 reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    pulse_cnt = 0;
    cyc(10);
    chk("reset_filter_sel", int'(bus.filter_sel), 0);
    chk("reset_level", int'(bus.level), 8);
    chk("reset_freeze", int'(bus.freeze), 0);
    chk("idle_no_pulse", pulse_cnt, 0);

    // Right cycling with wrap, then left wrap from 0.
    for (int k = 0; k < 7; k++) begin
      press(3, 2, 2);
      chk("right_step", int'(bus.filter_sel), exp_r[k]);
    end
    chk("right_pulses", pulse_cnt, 7);
    for (int k = 0; k < 5; k++) press(3, 2, 2);
    chk("right_to_zero", int'(bus.filter_sel), 0);
    pulse_cnt = 0;
    press(2, 2, 2);
    chk("left_wrap", int'(bus.filter_sel), 5);
    chk("left_pulse", pulse_cnt, 1);

    // Up held 40 cycles from level 8.
    do_reset();
    bus.btn[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
`ifdef LENS_FILTER_CTRL_AUTOREPEAT_EN
      exp_up = (k < 21) ? 9 : (k < 26) ? 10 : (k < 31) ? 11 : (k < 36) ? 12 : 13;
`else
      exp_up = 9;
`endif
      if (k == 1 || k == 20 || k == 21 || k == 26 || k == 31 || k == 36 || k == 40)
        chk("up_hold_level", int'(bus.level), exp_up);
    end
    bus.btn[0] = 1'b0;
    cyc(2);

    // Saturation at both ends.
    do_reset();
    for (int k = 0; k < 7; k++) press(0, 2, 2);
    chk("up_to_max", int'(bus.level), 15);
    pulse_cnt = 0;
    press(0, 2, 2);
    chk("up_saturated", int'(bus.level), 15);
    chk("up_sat_no_pulse", pulse_cnt, 0);
    for (int k = 0; k < 15; k++) press(1, 2, 2);
    chk("down_to_zero", int'(bus.level), 0);
    pulse_cnt = 0;
    press(1, 60, 2);
    chk("down_hold_sat", int'(bus.level), 0);
    chk("down_sat_no_pulse", pulse_cnt, 0);

    // Short centre press, then long press restoring defaults.
    do_reset();
    press(4, 5, 2);
    chk("short_freeze", int'(bus.freeze), 1);
    for (int k = 0; k < 3; k++) press(3, 2, 2);
    for (int k = 0; k < 6; k++) press(1, 2, 2);
    chk("pre_long_filter", int'(bus.filter_sel), 3);
    chk("pre_long_level", int'(bus.level), 2);
    bus.btn[4] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 29) chk("long_before_filter", int'(bus.filter_sel), 3);
      if (k == 30) begin
        chk("long_filter", int'(bus.filter_sel), 0);
        chk("long_level", int'(bus.level), 8);
        chk("long_freeze", int'(bus.freeze), 0);
        chk("long_pulse", int'(bus.cfg_changed), 1);
      end
    end
    bus.btn[4] = 1'b0;
    cyc(3);
    chk("long_release_no_toggle", int'(bus.freeze), 0);

    // Up and down together.
    do_reset();
    bus.btn[1:0] = 2'b11;
    cyc(30);
    bus.btn[1:0] = 2'b00;
    cyc(2);
    chk("updown_same_cycle", int'(bus.level), 8);

    // Asynchronous reset in the middle of a right hold.
    press(0, 2, 2);
    bus.btn[3] = 1'b1;
    cyc(5);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_filter", int'(bus.filter_sel), 0);
    chk("async_rst_level", int'(bus.level), 8);
    chk("async_rst_cfg", int'(bus.cfg_changed), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(2);
    chk("post_rst_rise", int'(bus.filter_sel), 1);
    bus.btn[3] = 1'b0;
    cyc(2);

    // Random held levels, checked every cycle against the model.
    for (int n = 0; n < 5000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 15) == 0) bus.btn[i] = ~bus.btn[i];
      if ($urandom_range(0, 39) == 0) bus.btn[4] = ~bus.btn[4];
      if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      cyc(1);
    end
    bus.btn = '0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
